// File: rtl/audio_pkg.sv
// Shared types, constants and song table contents for the melody playback path.
// Each table entry pairs a note code with a duration counted in 10 ms ticks.
package audio_pkg;

   localparam logic [3:0] NOTE_REST = 4'd0;
   localparam logic [7:0] DUR_END   = 8'd0;

   typedef struct packed {
      logic [3:0] note;
      logic [7:0] dur;
   } entry_t;

   typedef enum logic [2:0] {IDLE, FETCH, WAIT_ROM, PLAY, GAP, DONE} state_t;

   // Unlisted entries read as the terminator, so short songs end cleanly.
   function automatic entry_t song_entry(input logic [7:0] song, input logic [7:0] idx);
      entry_t e;
      e = '{note: NOTE_REST, dur: DUR_END};
      case (song)
         8'd0: begin
            case (idx)
               8'd0:    e = '{note: 4'd5, dur: 8'd3};
               8'd1:    e = '{note: 4'd7, dur: 8'd2};
               default: e = '{note: NOTE_REST, dur: DUR_END};
            endcase
         end
         8'd1: begin
            case (idx)
               8'd0:    e = '{note: NOTE_REST, dur: 8'd4};
               8'd1:    e = '{note: 4'd3, dur: 8'd1};
               default: e = '{note: NOTE_REST, dur: DUR_END};
            endcase
         end
         // Full-length song without a terminator: notes 1..15 repeating, one tick each.
         8'd2:    e = '{note: 4'(idx % 8'd15) + 4'd1, dur: 8'd1};
         8'd3: begin
            case (idx)
               8'd0:    e = '{note: 4'd9, dur: 8'd2};
               default: e = '{note: NOTE_REST, dur: DUR_END};
            endcase
         end
         default: e = '{note: NOTE_REST, dur: DUR_END};
      endcase
      return e;
   endfunction

endpackage

// File: rtl/melody_rom.sv
// Song table with a registered read: data for addr appears one clock later.
import audio_pkg::*;

module melody_rom #(
   parameter int SEL_W = 2,
   parameter int IDX_W = 5
) (
   input  logic                   clk,
   input  logic [SEL_W+IDX_W-1:0] addr,
   output logic [11:0]            entry
);

   always_ff @(posedge clk) begin
      entry <= song_entry(8'(addr[SEL_W+IDX_W-1:IDX_W]), 8'(addr[IDX_W-1:0]));
   end

endmodule

// File: rtl/melody_sequencer.sv
// Steps through a song's note table, timing each note and the gap after it
// on the external 10 ms tick, and drives the tone generator.
import audio_pkg::*;

module melody_sequencer #(
   parameter int NUM_SONGS = 4,
   parameter int SONG_LEN  = 32,
   parameter int GAP_TICKS = 2,
   parameter int SEL_W     = $clog2(NUM_SONGS),
   parameter int IDX_W     = $clog2(SONG_LEN)
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             tick,
   input  logic             start,
   input  logic             stop,
   input  logic [SEL_W-1:0] song_sel,
   output logic [3:0]       note_code,
   output logic             sound_en,
   output logic             busy,
   output logic             done
);

   localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

   state_t                   state;
   logic [SEL_W-1:0]         song;
   logic [IDX_W-1:0]         idx;
   logic [7:0]               dur_cnt;
   logic [GAP_W-1:0]         gap_cnt;
   logic [SEL_W+IDX_W-1:0]   rom_addr;
   logic [11:0]              rom_data;
   entry_t                   rom_q;
   logic                     last_idx;
   logic                     advance;

   assign rom_addr = {song, idx};
   assign rom_q    = entry_t'(rom_data);
   assign last_idx = (idx == IDX_W'(SONG_LEN - 1));

   // End of a note (no gap configured) or end of its gap: move to the next entry.
   assign advance = tick &&
                    ((state == PLAY && dur_cnt == 8'd1 && GAP_TICKS == 0) ||
                     (state == GAP  && gap_cnt == GAP_W'(1)));

   melody_rom #(
      .SEL_W(SEL_W),
      .IDX_W(IDX_W)
   ) u_rom (
      .clk  (clk),
      .addr (rom_addr),
      .entry(rom_data)
   );

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state     <= IDLE;
         song      <= '0;
         idx       <= '0;
         dur_cnt   <= '0;
         gap_cnt   <= '0;
         note_code <= NOTE_REST;
         sound_en  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (stop && state != IDLE) begin
            state     <= IDLE;
            note_code <= NOTE_REST;
            sound_en  <= 1'b0;
            busy      <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start && !stop) begin
                     song  <= song_sel;
                     idx   <= '0;
                     busy  <= 1'b1;
                     state <= FETCH;
                  end
               end
               FETCH: state <= WAIT_ROM;
               WAIT_ROM: begin
                  if (rom_q.dur == DUR_END) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state     <= PLAY;
                     dur_cnt   <= rom_q.dur;
                     note_code <= rom_q.note;
                     sound_en  <= (rom_q.note != NOTE_REST);
                  end
               end
               PLAY: begin
                  if (tick) begin
                     if (dur_cnt == 8'd1) begin
                        note_code <= NOTE_REST;
                        sound_en  <= 1'b0;
                        if (GAP_TICKS > 0) begin
                           state   <= GAP;
                           gap_cnt <= GAP_W'(GAP_TICKS);
                        end
                     end else begin
                        dur_cnt <= dur_cnt - 8'd1;
                     end
                  end
               end
               GAP: begin
                  if (tick && gap_cnt != GAP_W'(1)) gap_cnt <= gap_cnt - GAP_W'(1);
               end
               DONE: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase

            // Last table slot ends the song even without a terminator.
            if (advance) begin
               if (last_idx) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  idx   <= idx + IDX_W'(1);
                  state <= FETCH;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer: a cycle table for song 0 plus
// hand-written sequences for rests, stop, ignored start, full-length song and reset.
module tb_melody_sequencer;

   logic       clk = 1'b0;
   logic       resetN = 1'b0;
   logic       tick = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic [1:0] song_sel = 2'd0;
   logic [3:0] note_code;
   logic       sound_en;
   logic       busy;
   logic       done;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       t;
      logic       s;
      logic       p;
      logic [1:0] sel;
      logic [3:0] note;
      logic       snd;
      logic       bsy;
      logic       dn;
   } vec_t;

   vec_t vt[20];

   always #5 clk = ~clk;

   melody_sequencer #(
      .NUM_SONGS(4),
      .SONG_LEN (32),
      .GAP_TICKS(2)
   ) dut (
      .clk      (clk),
      .resetN   (resetN),
      .tick     (tick),
      .start    (start),
      .stop     (stop),
      .song_sel (song_sel),
      .note_code(note_code),
      .sound_en (sound_en),
      .busy     (busy),
      .done     (done)
   );

   function automatic vec_t mk(input logic t, input logic s, input logic p, input logic [1:0] sel,
                               input logic [3:0] n, input logic snd, input logic b, input logic d);
      vec_t v;
      v.t = t; v.s = s; v.p = p; v.sel = sel;
      v.note = n; v.snd = snd; v.bsy = b; v.dn = d;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_out(input string nm, input logic [3:0] n, input logic s, input logic b, input logic d);
      chk({nm, ".note"},  32'(note_code), 32'(n));
      chk({nm, ".sound"}, 32'(sound_en),  32'(s));
      chk({nm, ".busy"},  32'(busy),      32'(b));
      chk({nm, ".done"},  32'(done),      32'(d));
   endtask

   // Called at a negedge: drive inputs for one clock, return at the next negedge.
   task automatic cyc(input logic t, input logic s, input logic p, input logic [1:0] sel);
      tick = t; start = s; stop = p; song_sel = sel;
      @(negedge clk);
      tick = 1'b0; start = 1'b0; stop = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 1'b0, 2'd0);
   endtask

   initial begin
      // Song 0 at GAP_TICKS=2; ticks in FETCH/WAIT_ROM (rows 9,10) must be dropped.
      vt[0]  = mk(0,1,0,2'd0, 4'd0,0,1,0);
      vt[1]  = mk(0,0,0,2'd0, 4'd0,0,1,0);
      vt[2]  = mk(0,0,0,2'd0, 4'd5,1,1,0);
      vt[3]  = mk(1,0,0,2'd0, 4'd5,1,1,0);
      vt[4]  = mk(0,0,0,2'd0, 4'd5,1,1,0);
      vt[5]  = mk(1,0,0,2'd0, 4'd5,1,1,0);
      vt[6]  = mk(1,0,0,2'd0, 4'd0,0,1,0);
      vt[7]  = mk(1,0,0,2'd0, 4'd0,0,1,0);
      vt[8]  = mk(1,0,0,2'd0, 4'd0,0,1,0);
      vt[9]  = mk(1,0,0,2'd0, 4'd0,0,1,0);
      vt[10] = mk(1,0,0,2'd0, 4'd7,1,1,0);
      vt[11] = mk(1,0,0,2'd0, 4'd7,1,1,0);
      vt[12] = mk(1,0,0,2'd0, 4'd0,0,1,0);
      vt[13] = mk(1,0,0,2'd0, 4'd0,0,1,0);
      vt[14] = mk(1,0,0,2'd0, 4'd0,0,1,0);
      vt[15] = mk(0,0,0,2'd0, 4'd0,0,1,0);
      vt[16] = mk(0,0,0,2'd0, 4'd0,0,1,1);
      vt[17] = mk(0,0,0,2'd0, 4'd0,0,0,0);
      vt[18] = mk(0,1,1,2'd1, 4'd0,0,0,0);
      vt[19] = mk(0,0,0,2'd0, 4'd0,0,0,0);

      repeat (2) @(negedge clk);
      chk_out("reset", 4'd0, 0, 0, 0);
      resetN = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 20; i++) begin
         cyc(vt[i].t, vt[i].s, vt[i].p, vt[i].sel);
         chk_out($sformatf("vec%0d", i), vt[i].note, vt[i].snd, vt[i].bsy, vt[i].dn);
      end

      // Rest entry (0,4): silent but busy for four ticks, then the next note plays.
      cyc(0,1,0,2'd1); cyc(0,0,0,2'd0); cyc(0,0,0,2'd0);
      chk_out("rest_play", 4'd0, 0, 1, 0);
      for (int k = 0; k < 4; k++) begin
         cyc(1,0,0,2'd0);
         chk_out($sformatf("rest_tick%0d", k), 4'd0, 0, 1, 0);
      end
      ticks(2); cyc(0,0,0,2'd0); cyc(0,0,0,2'd0);
      chk_out("rest_next", 4'd3, 1, 1, 0);
      cyc(0,0,1,2'd0);
      chk_out("rest_stop", 4'd0, 0, 0, 0);

      // Stop on the second tick of note 7, then replay from the first entry.
      cyc(0,1,0,2'd0); cyc(0,0,0,2'd0); cyc(0,0,0,2'd0);
      ticks(5); cyc(0,0,0,2'd0); cyc(0,0,0,2'd0);
      chk_out("stop_pre", 4'd7, 1, 1, 0);
      ticks(1);
      cyc(1,0,1,2'd0);
      chk_out("stop", 4'd0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         cyc(1,0,0,2'd0);
         chk_out($sformatf("stop_idle%0d", k), 4'd0, 0, 0, 0);
      end
      cyc(0,1,0,2'd0); cyc(0,0,0,2'd0); cyc(0,0,0,2'd0);
      chk_out("replay", 4'd5, 1, 1, 0);

      // Start with a different song_sel while playing is ignored.
      cyc(0,1,0,2'd3);
      chk_out("start_ignored", 4'd5, 1, 1, 0);
      ticks(5); cyc(0,0,0,2'd0); cyc(0,0,0,2'd0);
      chk_out("same_song", 4'd7, 1, 1, 0);
      ticks(4); cyc(0,0,0,2'd0); cyc(0,0,0,2'd0);
      chk_out("same_song_done", 4'd0, 0, 1, 1);
      cyc(0,0,0,2'd0);
      chk_out("same_song_idle", 4'd0, 0, 0, 0);

      // Song 2 fills all 32 slots with no terminator; it must end without wrapping.
      cyc(0,1,0,2'd2); cyc(0,0,0,2'd0); cyc(0,0,0,2'd0);
      for (int i = 0; i < 32; i++) begin
         chk_out($sformatf("full%0d", i), 4'((i % 15) + 1), 1, 1, 0);
         ticks(3);
         if (i < 31) begin
            cyc(0,0,0,2'd0); cyc(0,0,0,2'd0);
         end
      end
      chk_out("full_done", 4'd0, 0, 1, 1);
      cyc(0,0,0,2'd0);
      chk_out("full_idle", 4'd0, 0, 0, 0);
      cyc(1,0,0,2'd0); cyc(0,0,0,2'd0); cyc(0,0,0,2'd0);
      chk_out("full_nowrap", 4'd0, 0, 0, 0);

      // Asynchronous reset mid-note clears outputs before any clock edge.
      cyc(0,1,0,2'd0); cyc(0,0,0,2'd0); cyc(0,0,0,2'd0); ticks(1);
      chk_out("pre_reset", 4'd5, 1, 1, 0);
      #2 resetN = 1'b0;
      #1 chk_out("async_reset", 4'd0, 0, 0, 0);
      @(negedge clk);
      resetN = 1'b1;
      ticks(4);
      chk_out("reset_idle", 4'd0, 0, 0, 0);
      cyc(0,1,0,2'd0); cyc(0,0,0,2'd0); cyc(0,0,0,2'd0);
      chk_out("after_reset", 4'd5, 1, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Plays a stored melody note by note in the audio path. It sits directly downstream of the hundredth-second tick counter and consumes its `tick` pulse as the duration time base. It steps through a per-song note table and drives the note code and sound enable into the tone generator. It reports `busy` while playing and pulses `done` at the natural end of a song.

## Interface
Parameters:
- NUM_SONGS, 4: number of songs in the table; song index width SEL_W = $clog2(NUM_SONGS).
- SONG_LEN, 32: entries per song; index width IDX_W = $clog2(SONG_LEN).
- GAP_TICKS, 2: silent ticks inserted after every note. 0 means no gap.

Ports:
- clk  in  1  system clock.
- resetN  in  1  reset, asynchronous, active-low.
- tick  in  1  one-cycle pulse from the hundredth-second counter (1 tick = 10 ms).
- start  in  1  one-cycle request to play the song selected by song_sel.
- stop  in  1  one-cycle abort request.
- song_sel  in  SEL_W  song index, sampled only on an accepted start.
- note_code  out  4  note index to the tone generator; 0 = rest.
- sound_en  out  1  tone generator enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on natural song completion.

## Operation
- Table entry is 12 bits: note[11:8], dur[7:0] in ticks.
  - dur == 0 is the end-of-song terminator.
  - note == 0 is a rest: the entry is timed normally with sound_en low.
- The table is read through a ROM with 1-cycle registered read latency. Address = {song, idx}.
- States: IDLE, FETCH, WAIT_ROM, PLAY, GAP, DONE.
- IDLE
  - start && !stop → FETCH. Latch song_sel and set idx = 0.
  - start while not in IDLE is ignored.
- FETCH: drive the address → WAIT_ROM.
- WAIT_ROM: ROM data becomes valid.
  - dur == 0 → DONE.
  - Otherwise → PLAY. Load dur_cnt = dur and register note_code = note, sound_en = (note != 0).
- PLAY: each tick decrements dur_cnt. A tick with dur_cnt == 1 leaves PLAY:
  - → GAP if GAP_TICKS > 0. Load gap_cnt = GAP_TICKS; note_code = 0, sound_en = 0.
  - Otherwise → ADVANCE.
- GAP: each tick decrements gap_cnt. A tick with gap_cnt == 1 → ADVANCE.
- ADVANCE is an action, not a state:
  - If idx == SONG_LEN-1 → DONE (no wrap into the next song).
  - Otherwise idx + 1 → FETCH.
- DONE: done = 1 for exactly one cycle, outputs cleared → IDLE.
- stop in any non-IDLE state: next cycle is IDLE with note_code = 0, sound_en = 0, busy = 0, and no done pulse. stop has priority over everything else, including tick and start in the same cycle.
- Ticks arriving in FETCH or WAIT_ROM are dropped, not queued.
- Widths: dur_cnt is 8 bits; gap_cnt is $clog2(GAP_TICKS+1) bits, minimum 1. Counters never underflow because exit happens at a count of 1.

## Timing
- Reset values: note_code = 0, sound_en = 0, busy = 0, done = 0, state IDLE, idx = 0.
- Start latency: start sampled at cycle 0.
  - Cycle 1: FETCH; busy = 1.
  - Cycle 2: WAIT_ROM.
  - Cycle 3: PLAY, with note_code/sound_en valid.
- Note length = exactly dur ticks counted from the first tick seen in PLAY. sound_en falls in the cycle after the last counted tick.
- Inter-note overhead is 2 clocks (FETCH, WAIT_ROM) plus GAP_TICKS ticks.
- done rises 1 cycle after the terminator is read or the last GAP completes. busy falls in the same cycle done falls.
- All outputs are registered, with no combinational path from any input to any output.
- Reset asserted mid-song returns all outputs to reset values immediately (asynchronous). Operation resumes only on a new start.

## Structure
- Package audio_pkg holds:
  - the entry typedef (struct: note, dur);
  - the state enum;
  - the constants NOTE_REST = 0, DUR_END = 0;
  - the song table contents.
- Sub-module melody_rom holds the registered table read (addr in, entry out, 1-cycle latency). The top module holds the FSM and counters.

## Test plan
- Song 0 = {(5,3),(7,2),(0,0)}, GAP_TICKS = 2, tick every 10 clk:
  - note_code = 5 with sound_en = 1 for 3 ticks, then 2 silent ticks;
  - then note_code = 7 for 2 ticks, then 2 silent ticks;
  - then done pulses once and busy = 0.
- Rest entry (0,4): sound_en = 0 and note_code = 0 for 4 ticks, with busy = 1 throughout.
- stop asserted in the second tick of a note:
  - next cycle sound_en = 0, busy = 0, no done pulse;
  - a new start replays the song from idx 0.
- start pulsed during PLAY with song_sel changed: ignored, and the current song continues unchanged.
- Song with SONG_LEN entries and no terminator: done pulses after the last entry's gap, and idx does not wrap into the next song.
- resetN asserted low mid-note: all outputs are 0 asynchronously, and after release the block stays IDLE until start.
